// File: rtl/sd_wav_pingpong_buf.sv
// Ping-pong byte buffer between the SD-card reader and the WAV playback path.
// Optional build macro UNDERRUN_MUTE_EN: an underrun read returns silence instead of the last frame.
module sd_wav_pingpong_buf #(
  parameter int          SAMPLE_BITS = 16,
  parameter int          CHANNELS    = 2,
  parameter int          BANK_BYTES  = 4096,
  parameter logic [31:0] SADDR       = 32'h00421e00,
  parameter logic [31:0] EADDR       = 32'h036e7100,
  parameter logic [31:0] SEC_STEP    = 32'h00000200
) (
  input  logic                            clk_50M,
  input  logic                            init,
  input  logic                            start,
  output logic                            sd_req,
  output logic [31:0]                     sd_sec,
  input  logic                            sec_done,
  input  logic [7:0]                      byte_in,
  input  logic                            byte_valid,
  input  logic                            smp_rden,
  output logic [SAMPLE_BITS*CHANNELS-1:0] smp_data,
  output logic                            smp_valid,
  output logic [1:0]                      level,
  output logic                            underrun,
  output logic                            overflow
);

  localparam int FB = CHANNELS * SAMPLE_BITS / 8;
  localparam int FW = SAMPLE_BITS * CHANNELS;
  localparam int AW = $clog2(BANK_BYTES);
  localparam logic [AW-1:0] WLAST = AW'(BANK_BYTES - 1);
  localparam logic [AW-1:0] RLAST = AW'(BANK_BYTES - FB);
  localparam logic [AW-1:0] FB_A  = AW'(FB);
  localparam logic [AW-1:0] ONE_A = AW'(1);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_FILL = 2'd1,
    F_WAIT = 2'd2
  } fill_state_t;

  fill_state_t   state_r;
  logic          wb_r;
  logic          rb_r;
  logic [AW-1:0] waddr_r;
  logic [AW-1:0] raddr_r;
  logic [1:0]    full_r;
  logic [7:0]    mem_r [0:(2**(AW+1))-1];

  logic          wr_en_s;
  logic          wr_last_s;
  logic          rd_hit_s;
  logic          rd_last_s;
  logic          udr_s;
  logic [1:0]    set_s;
  logic [1:0]    clr_s;
  logic [1:0]    full_nxt_s;
  logic [FW-1:0] frame_s;

  // Write/read qualifiers and next bank-full state; start overrides everything.
  always_comb begin
    wr_en_s    = byte_valid && !start && (state_r == F_FILL);
    wr_last_s  = wr_en_s && (waddr_r == WLAST);
    rd_hit_s   = smp_rden && !start && full_r[rb_r];
    rd_last_s  = rd_hit_s && (raddr_r == RLAST);
    udr_s      = smp_rden && !rd_hit_s;
    set_s      = wr_last_s ? (wb_r ? 2'b10 : 2'b01) : 2'b00;
    clr_s      = rd_last_s ? (rb_r ? 2'b10 : 2'b01) : 2'b00;
    full_nxt_s = start ? 2'b00 : ((full_r | set_s) & ~clr_s);
  end

  // Gather one frame from the reader bank, byte 0 in the LSBs.
  always_comb begin
    frame_s = '0;
    for (int k = 0; k < FB; k++) begin
      frame_s[8*k +: 8] = mem_r[{rb_r, raddr_r + AW'(k)}];
    end
  end

  // Sample storage; contents are meaningless until the full flag says otherwise, so no reset.
  always_ff @(posedge clk_50M) begin
    if (wr_en_s) begin
      mem_r[{wb_r, waddr_r}] <= byte_in;
    end
  end

  // Fill FSM, writer pointer and sticky overflow.
  always_ff @(posedge clk_50M or negedge init) begin
    if (!init) begin
      state_r  <= F_IDLE;
      sd_req   <= 1'b0;
      wb_r     <= 1'b0;
      waddr_r  <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      state_r  <= F_FILL;
      sd_req   <= 1'b1;
      wb_r     <= 1'b0;
      waddr_r  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state_r)
        F_IDLE: begin
          sd_req   <= 1'b0;
          overflow <= overflow | byte_valid;
        end
        F_FILL: begin
          if (wr_last_s) begin
            waddr_r <= '0;
            wb_r    <= ~wb_r;
            state_r <= F_WAIT;
            sd_req  <= 1'b0;
          end else if (wr_en_s) begin
            waddr_r <= waddr_r + ONE_A;
          end
        end
        F_WAIT: begin
          overflow <= overflow | byte_valid;
          if (!full_r[wb_r]) begin
            state_r <= F_FILL;
            sd_req  <= 1'b1;
          end
        end
        default: begin
          state_r <= F_IDLE;
          sd_req  <= 1'b0;
        end
      endcase
    end
  end

  // Reader pointer and frame output; a start-cycle read is treated as an unreported underrun.
  always_ff @(posedge clk_50M or negedge init) begin
    if (!init) begin
      rb_r      <= 1'b0;
      raddr_r   <= '0;
      smp_data  <= '0;
      smp_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      smp_valid <= smp_rden;
      underrun  <= udr_s && !start;
      if (start) begin
        rb_r    <= 1'b0;
        raddr_r <= '0;
      end else if (rd_last_s) begin
        rb_r    <= ~rb_r;
        raddr_r <= '0;
      end else if (rd_hit_s) begin
        raddr_r <= raddr_r + FB_A;
      end
      if (rd_hit_s) begin
        smp_data <= frame_s;
      end
`ifdef UNDERRUN_MUTE_EN
      else if (udr_s) begin
        smp_data <= '0;
      end
`endif
    end
  end

  // Bank-full flags and the registered fill level.
  always_ff @(posedge clk_50M or negedge init) begin
    if (!init) begin
      full_r <= 2'b00;
      level  <= 2'd0;
    end else begin
      full_r <= full_nxt_s;
      level  <= {1'b0, full_nxt_s[0]} + {1'b0, full_nxt_s[1]};
    end
  end

  // SD sector address sequencer, wrapping from EADDR back to SADDR.
  always_ff @(posedge clk_50M or negedge init) begin
    if (!init) begin
      sd_sec <= SADDR;
    end else if (start) begin
      sd_sec <= SADDR;
    end else if (sec_done) begin
      sd_sec <= (sd_sec < EADDR) ? (sd_sec + SEC_STEP) : SADDR;
    end
  end

endmodule

// File: tb/tb_sd_wav_pingpong_buf.sv
// Directed self-checking bench for sd_wav_pingpong_buf (16-bit stereo, 4096-byte banks).
module tb_sd_wav_pingpong_buf;

  localparam int          BANK    = 4096;
  localparam logic [31:0] SADDR_T = 32'h036e6f00;
  localparam logic [31:0] EADDR_T = 32'h036e7100;
  localparam logic [31:0] STEP_T  = 32'h00000200;

  logic        clk_50M = 1'b0;
  logic        init = 1'b0;
  logic        start = 1'b0;
  logic        sd_req;
  logic [31:0] sd_sec;
  logic        sec_done = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        smp_rden = 1'b0;
  logic [31:0] smp_data;
  logic        smp_valid;
  logic [1:0]  level;
  logic        underrun;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  sd_wav_pingpong_buf #(
    .SAMPLE_BITS(16), .CHANNELS(2), .BANK_BYTES(BANK),
    .SADDR(SADDR_T), .EADDR(EADDR_T), .SEC_STEP(STEP_T)
  ) dut (
    .clk_50M(clk_50M), .init(init), .start(start), .sd_req(sd_req), .sd_sec(sd_sec),
    .sec_done(sec_done), .byte_in(byte_in), .byte_valid(byte_valid), .smp_rden(smp_rden),
    .smp_data(smp_data), .smp_valid(smp_valid), .level(level), .underrun(underrun),
    .overflow(overflow)
  );

  always #5 clk_50M = ~clk_50M;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fexp(input int j, input logic [7:0] x);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(j) ^ x;
    b1 = 8'(j + 1) ^ x;
    b2 = 8'(j + 2) ^ x;
    b3 = 8'(j + 3) ^ x;
    return {b3, b2, b1, b0};
  endfunction

  task automatic fill_bank(input logic [7:0] x);
    for (int i = 0; i < BANK; i++) begin
      byte_in    = 8'(i) ^ x;
      byte_valid = 1'b1;
      @(negedge clk_50M);
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_sec(input logic [31:0] exp, input string tag);
    sec_done = 1'b1;
    @(negedge clk_50M);
    sec_done = 1'b0;
    check(tag, sd_sec, exp);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk_50M);
    check("rst_sd_req", sd_req, 1'b0);
    check("rst_sd_sec", sd_sec, SADDR_T);
    check("rst_level", level, 2'd0);
    check("rst_smp_data", smp_data, 32'h0);
    check("rst_smp_valid", smp_valid, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    init = 1'b1;
    @(negedge clk_50M);
    check("idle_sd_req", sd_req, 1'b0);

    start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    check("start_sd_req", sd_req, 1'b1);

    // Fill both banks; bank1 pattern differs so the reader bank is identifiable
    fill_bank(8'h00);
    check("bank0_done_sd_req", sd_req, 1'b0);
    check("bank0_done_level", level, 2'd1);
    @(negedge clk_50M);
    check("refill_sd_req", sd_req, 1'b1);
    fill_bank(8'hA5);
    check("bank1_done_level", level, 2'd2);
    repeat (3) @(negedge clk_50M);
    check("full_sd_req", sd_req, 1'b0);

    // A byte in F_WAIT is dropped and raises overflow
    byte_in    = 8'hEE;
    byte_valid = 1'b1;
    @(negedge clk_50M);
    byte_valid = 1'b0;
    check("ovf_set", overflow, 1'b1);

    // Drain bank0 frame by frame
    for (int k = 0; k < BANK / 4; k++) begin
      smp_rden = 1'b1;
      @(negedge clk_50M);
      check("b0_valid", smp_valid, 1'b1);
      check("b0_frame", smp_data, fexp(4 * k, 8'h00));
    end
    smp_rden = 1'b0;
    check("b0_last_literal", smp_data, 32'hfffefdfc);
    check("drain_level", level, 2'd1);
    check("drain_sd_req_lo", sd_req, 1'b0);
    @(negedge clk_50M);
    check("drain_valid_drop", smp_valid, 1'b0);
    check("drain_sd_req_hi", sd_req, 1'b1);

    // Reader moved to bank1; read up to raddr=100
    smp_rden = 1'b1;
    @(negedge clk_50M);
    check("b1_first", smp_data, 32'ha6a7a4a5);
    for (int k = 1; k < 25; k++) begin
      @(negedge clk_50M);
      check("b1_frame", smp_data, fexp(4 * k, 8'hA5));
    end
    smp_rden = 1'b0;
    check("b1_level", level, 2'd1);
    check("b1_underrun", underrun, 1'b0);

    // Sector address wrap
    pulse_sec(EADDR_T, "sec_1");
    pulse_sec(SADDR_T, "sec_2");
    pulse_sec(SADDR_T + STEP_T, "sec_3");

    // Restart mid-stream
    start = 1'b1;
    @(negedge clk_50M);
    start = 1'b0;
    check("restart_level", level, 2'd0);
    check("restart_sd_sec", sd_sec, SADDR_T);
    check("restart_sd_req", sd_req, 1'b1);
    check("restart_overflow", overflow, 1'b0);

    // Underrun with no full bank
    smp_rden = 1'b1;
    @(negedge clk_50M);
    smp_rden = 1'b0;
    check("udr_pulse", underrun, 1'b1);
    check("udr_valid", smp_valid, 1'b1);
`ifdef UNDERRUN_MUTE_EN
    check("udr_data", smp_data, 32'h0);
`else
    check("udr_data", smp_data, 32'hc6c7c4c5);
`endif
    check("udr_level", level, 2'd0);
    @(negedge clk_50M);
    check("udr_drop", underrun, 1'b0);

    // After restart the first byte lands at bank0 address 0
    fill_bank(8'h3C);
    check("post_fill_level", level, 2'd1);
    smp_rden = 1'b1;
    @(negedge clk_50M);
    smp_rden = 1'b0;
    check("post_first", smp_data, 32'h3f3e3d3c);
    check("post_underrun", underrun, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
